// File: rtl/rr_peak_reader.sv
// rr_peak_reader: R-peak picker for the QRS detector output stream.
// Finds the maximum of each above-threshold excursion, enforces a refractory
// window after every accepted beat, reports the R-R interval in samples and
// flags a timeout when no beat arrives for MAX_RR samples.
module rr_peak_reader #(
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 16,
   parameter int REFRACTORY = 50,
   parameter int MAX_RR     = 2000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] dn,
   input  logic signed [DATA_W-1:0] threshold,
   output logic                     beat,
   output logic signed [DATA_W-1:0] peak_val,
   output logic        [CNT_W-1:0]  rr_interval,
   output logic                     rr_valid,
   output logic                     timeout
);

   localparam int RW = $clog2(REFRACTORY + 1);

   typedef enum logic [1:0] {WAIT_LOW, SEARCH, TRACK, REFRAC} state_t;

   state_t                   state, state_n;
   logic signed [DATA_W-1:0] peak_reg;
   logic        [CNT_W-1:0]  idx;
   logic        [CNT_W-1:0]  peak_idx;
   logic        [CNT_W-1:0]  last_idx;
   logic        [CNT_W-1:0]  since_cnt;
   logic        [RW-1:0]     refr_cnt;
   logic                     has_prev;
   logic                     above;
   logic                     load_peak;
   logic                     accept;
   logic                     tmo_hit;

   // Next-state decode; the FSM only moves on a valid sample. Equality with
   // the threshold counts as below, and a tie in TRACK keeps the earlier peak.
   always_comb begin
      state_n   = state;
      load_peak = 1'b0;
      accept    = 1'b0;
      above     = (dn > threshold);
      if (in_valid) begin
         case (state)
            WAIT_LOW: if (!above) state_n = SEARCH;
            SEARCH: begin
               if (above) begin
                  load_peak = 1'b1;
                  state_n   = TRACK;
               end
            end
            TRACK: begin
               if (above) begin
                  if (dn > peak_reg) load_peak = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_n = REFRAC;
               end
            end
            REFRAC: if (refr_cnt == RW'(REFRACTORY - 1)) state_n = WAIT_LOW;
            default: state_n = WAIT_LOW;
         endcase
      end
      // A beat on the same sample as the MAX_RR crossing suppresses the timeout.
      tmo_hit = in_valid && !accept && has_prev && (since_cnt == CNT_W'(MAX_RR - 1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= WAIT_LOW;
      else     state <= state_n;
   end

   // Sample index, refractory/timeout counters and the history flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         refr_cnt  <= '0;
         since_cnt <= '0;
         has_prev  <= 1'b0;
         last_idx  <= '0;
      end else if (in_valid) begin
         idx <= idx + 1'b1;
         if (accept)              refr_cnt <= '0;
         else if (state == REFRAC) refr_cnt <= refr_cnt + 1'b1;
         if (accept)                          since_cnt <= '0;
         else if (since_cnt != CNT_W'(MAX_RR)) since_cnt <= since_cnt + 1'b1;
         if (accept)       has_prev <= 1'b1;
         else if (tmo_hit) has_prev <= 1'b0;
         if (accept) last_idx <= peak_idx;
      end
   end

   // Running peak of the current excursion; always loaded before it is read.
   always_ff @(posedge clk) begin
      if (in_valid && load_peak) begin
         peak_reg <= dn;
         peak_idx <= idx;
      end
   end

   // Registered outputs: single-cycle pulses plus held peak and interval.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat        <= 1'b0;
         rr_valid    <= 1'b0;
         timeout     <= 1'b0;
         peak_val    <= '0;
         rr_interval <= '0;
      end else begin
         beat     <= accept;
         rr_valid <= accept && has_prev;
         timeout  <= tmo_hit;
         if (accept) begin
            peak_val    <= peak_reg;
            rr_interval <= peak_idx - last_idx;
         end
      end
   end

endmodule

// File: tb/tb_rr_peak_reader.sv
// Directed bench for rr_peak_reader (REFRACTORY=50, MAX_RR=200).
module tb_rr_peak_reader;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               in_valid = 1'b0;
   logic signed [31:0] dn = '0;
   logic signed [31:0] threshold = '0;
   logic               beat;
   logic signed [31:0] peak_val;
   logic        [15:0] rr_interval;
   logic               rr_valid;
   logic               timeout;

   int checks = 0;
   int failures = 0;
   int beat_cnt = 0;
   int tmo_cnt = 0;
   int b0;

   rr_peak_reader #(.DATA_W(32), .CNT_W(16), .REFRACTORY(50), .MAX_RR(200)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .dn(dn), .threshold(threshold),
      .beat(beat), .peak_val(peak_val), .rr_interval(rr_interval),
      .rr_valid(rr_valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One valid sample; outputs reflecting it are visible on return.
   task automatic send(input int d, input int t);
      in_valid = 1'b1; dn = d; threshold = t;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (beat === 1'b1) beat_cnt++;
      if (timeout === 1'b1) tmo_cnt++;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
         if (beat === 1'b1) beat_cnt++;
         if (timeout === 1'b1) tmo_cnt++;
      end
   endtask

   task automatic test_reset();
      in_valid = 1'b1; dn = 500; threshold = 0;
      do_reset();
      checks++; if (beat !== 1'b0) begin failures++; $display("FAIL reset_beat: got %0b want 0", beat); end
      checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL reset_rr_valid: got %0b want 0", rr_valid); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
      checks++; if (peak_val !== 32'sd0) begin failures++; $display("FAIL reset_peak_val: got %0d want 0", peak_val); end
      checks++; if (rr_interval !== 16'd0) begin failures++; $display("FAIL reset_rr_interval: got %0d want 0", rr_interval); end
   endtask

   task automatic test_basic();
      do_reset();
      b0 = beat_cnt;
      send(0, 100); send(150, 100); send(300, 100); send(200, 100);
      checks++; if (beat_cnt != b0) begin failures++; $display("FAIL basic_early_beat: got %0d beats want 0", beat_cnt - b0); end
      send(50, 100); // idx 4
      checks++; if (beat !== 1'b1) begin failures++; $display("FAIL basic_beat: got %0b want 1", beat); end
      checks++; if (peak_val !== 32'sd300) begin failures++; $display("FAIL basic_peak_val: got %0d want 300", peak_val); end
      checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL basic_rr_valid: got %0b want 0", rr_valid); end
      send(50, 100); // idx 5, pulse must drop even with back-to-back valid
      checks++; if (beat !== 1'b0) begin failures++; $display("FAIL basic_pulse_width: got %0b want 0", beat); end
   endtask

   task automatic test_refractory();
      b0 = beat_cnt;
      for (int i = 6; i < 20; i++) send(50, 100);
      send(400, 100); send(400, 100); send(400, 100); // idx 20..22
      for (int i = 23; i < 100; i++) send(50, 100);
      checks++; if (beat_cnt != b0) begin failures++; $display("FAIL refr_beats: got %0d want 0", beat_cnt - b0); end
      checks++; if (peak_val !== 32'sd300) begin failures++; $display("FAIL refr_peak_val: got %0d want 300", peak_val); end
   endtask

   task automatic test_second_beat();
      b0 = beat_cnt;
      send(150, 100); send(200, 100); send(300, 100); send(200, 100); // idx 100..103, peak at 102
      send(50, 100); // idx 104
      checks++; if (beat !== 1'b1) begin failures++; $display("FAIL second_beat: got %0b want 1", beat); end
      checks++; if (rr_interval !== 16'd100) begin failures++; $display("FAIL second_rr_interval: got %0d want 100", rr_interval); end
      checks++; if (rr_valid !== 1'b1) begin failures++; $display("FAIL second_rr_valid: got %0b want 1", rr_valid); end
      checks++; if (beat_cnt != b0 + 1) begin failures++; $display("FAIL second_beat_count: got %0d want 1", beat_cnt - b0); end
   endtask

   task automatic test_timeout();
      tmo_cnt = 0;
      for (int i = 105; i < 304; i++) send(50, 100);
      checks++; if (tmo_cnt != 0) begin failures++; $display("FAIL tmo_early: got %0d pulses want 0", tmo_cnt); end
      send(50, 100); // idx 304: 200th sample since the beat
      checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL tmo_pulse: got %0b want 1", timeout); end
      send(50, 100); // idx 305
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL tmo_pulse_width: got %0b want 0", timeout); end
      send(300, 100); // idx 306
      send(50, 100);  // idx 307
      checks++; if (beat !== 1'b1) begin failures++; $display("FAIL tmo_next_beat: got %0b want 1", beat); end
      checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL tmo_rr_valid: got %0b want 0", rr_valid); end
      checks++; if (rr_interval !== 16'd204) begin failures++; $display("FAIL tmo_rr_interval: got %0d want 204", rr_interval); end
      checks++; if (tmo_cnt != 1) begin failures++; $display("FAIL tmo_count: got %0d want 1", tmo_cnt); end
   endtask

   task automatic test_start_high();
      do_reset();
      b0 = beat_cnt;
      for (int i = 0; i < 10; i++) send(500, 100);
      send(50, 100);
      checks++; if (beat_cnt != b0) begin failures++; $display("FAIL starthigh_false_beat: got %0d want 0", beat_cnt - b0); end
      send(200, 100); send(50, 100);
      checks++; if (beat_cnt != b0 + 1) begin failures++; $display("FAIL starthigh_count: got %0d want 1", beat_cnt - b0); end
      checks++; if (peak_val !== 32'sd200) begin failures++; $display("FAIL starthigh_peak_val: got %0d want 200", peak_val); end
   endtask

   task automatic test_gaps();
      do_reset();
      b0 = beat_cnt;
      send(0, 100); idle(3); send(150, 100); idle(3); send(300, 100); idle(3);
      send(200, 100); idle(3);
      checks++; if (beat_cnt != b0) begin failures++; $display("FAIL gaps_early_beat: got %0d want 0", beat_cnt - b0); end
      send(50, 100);
      checks++; if (beat !== 1'b1) begin failures++; $display("FAIL gaps_beat: got %0b want 1", beat); end
      checks++; if (peak_val !== 32'sd300) begin failures++; $display("FAIL gaps_peak_val: got %0d want 300", peak_val); end
      checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL gaps_rr_valid: got %0b want 0", rr_valid); end
      idle(3);
      checks++; if (beat_cnt != b0 + 1) begin failures++; $display("FAIL gaps_count: got %0d want 1", beat_cnt - b0); end
      checks++; if (peak_val !== 32'sd300) begin failures++; $display("FAIL gaps_hold: got %0d want 300", peak_val); end
   endtask

   task automatic test_rst_track();
      for (int i = 0; i < 51; i++) send(50, 100); // refractory, then WAIT_LOW -> SEARCH
      send(350, 100); // into TRACK
      b0 = beat_cnt;
      rst = 1'b1; in_valid = 1'b1; dn = 50; threshold = 100;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      checks++; if (beat !== 1'b0) begin failures++; $display("FAIL rsttrack_beat: got %0b want 0", beat); end
      checks++; if (peak_val !== 32'sd0) begin failures++; $display("FAIL rsttrack_peak_val: got %0d want 0", peak_val); end
      checks++; if (rr_interval !== 16'd0) begin failures++; $display("FAIL rsttrack_rr_interval: got %0d want 0", rr_interval); end
      send(50, 100);
      checks++; if (beat_cnt != b0) begin failures++; $display("FAIL rsttrack_count: got %0d want 0", beat_cnt - b0); end
   endtask

   task automatic test_signed_ties();
      do_reset();
      send(-20, -10); send(-5, -10); send(-5, -10); // peak at idx 1, tie at idx 2
      send(-30, -10); // idx 3
      checks++; if (beat !== 1'b1) begin failures++; $display("FAIL signed_beat: got %0b want 1", beat); end
      checks++; if (peak_val !== -32'sd5) begin failures++; $display("FAIL signed_peak_val: got %0d want -5", peak_val); end
      for (int i = 4; i < 55; i++) send(-30, -10);
      send(-5, -10);  // idx 55
      send(-30, -10); // idx 56
      checks++; if (rr_interval !== 16'd54) begin failures++; $display("FAIL tie_rr_interval: got %0d want 54", rr_interval); end
      checks++; if (rr_valid !== 1'b1) begin failures++; $display("FAIL tie_rr_valid: got %0b want 1", rr_valid); end
   endtask

   task automatic test_equal();
      do_reset();
      b0 = beat_cnt;
      send(5, 100);
      for (int i = 0; i < 5; i++) send(100, 100);
      send(5, 100);
      send(-10, -10); send(-20, -10);
      checks++; if (beat_cnt != b0) begin failures++; $display("FAIL equal_no_track: got %0d beats want 0", beat_cnt - b0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_refractory();
      test_second_beat();
      test_timeout();
      test_start_high();
      test_gaps();
      test_rst_track();
      test_signed_ties();
      test_equal();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
